// File: rtl/rps_match_scorer_pkg.sv
// Shared codes for the rock-paper-scissors scorer: move, round and match encodings,
// FSM states and the "who beats whom" rule.
package rps_match_scorer_pkg;

  typedef enum logic [1:0] {
    MV_NONE     = 2'b00,
    MV_ROCK     = 2'b01,
    MV_SCISSORS = 2'b10,
    MV_PAPER    = 2'b11
  } move_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_B    = 2'b01,
    RES_A    = 2'b10,
    RES_DRAW = 2'b11
  } res_e;

  typedef enum logic [1:0] {
    PL_PLAY = 2'b00,
    PL_B    = 2'b01,
    PL_A    = 2'b10,
    PL_TIE  = 2'b11
  } match_e;

  typedef enum logic {
    StPlay,
    StDone
  } state_e;

  function automatic logic beats(input logic [1:0] x, input logic [1:0] y);
    return ((x == MV_ROCK)     && (y == MV_SCISSORS)) ||
           ((x == MV_SCISSORS) && (y == MV_PAPER))    ||
           ((x == MV_PAPER)    && (y == MV_ROCK));
  endfunction

endpackage

// File: rtl/rps_match_scorer_if.sv
// Round-strobe / score bus between the key front end, the scorer and the display logic.
interface rps_match_scorer_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               clr;
  logic               start;
  logic [1:0]         move_a;
  logic [1:0]         move_b;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic [SCORE_W-1:0] draws;
  logic [SCORE_W-1:0] rounds;
  logic               round_vld;
  logic [1:0]         round_res;
  logic               bad_move;
  logic [1:0]         player;
  logic               over;

  modport master (
    output clr, start, move_a, move_b,
    input  score_a, score_b, draws, rounds, round_vld, round_res, bad_move, player, over
  );

  modport slave (
    input  clr, start, move_a, move_b,
    output score_a, score_b, draws, rounds, round_vld, round_res, bad_move, player, over
  );
endinterface

// File: rtl/rps_match_scorer_judge.sv
// Combinational round judge: two moves in, round result and invalid-move flag out.
module rps_match_scorer_judge
  import rps_match_scorer_pkg::*;
(
  input  logic [1:0] move_a,
  input  logic [1:0] move_b,
  output res_e       res,
  output logic       invalid
);

  always_comb begin
    invalid = (move_a == MV_NONE) || (move_b == MV_NONE);
    res     = RES_NONE;
    if (!invalid) begin
      if (move_a == move_b) begin
        res = RES_DRAW;
      end else if (beats(move_a, move_b)) begin
        res = RES_A;
      end else begin
        res = RES_B;
      end
    end
  end

endmodule

// File: rtl/rps_match_scorer.sv
// Match scorer: judges rounds, keeps win/draw tallies and decides the match on the same
// edge as the deciding score update.
module rps_match_scorer
  import rps_match_scorer_pkg::*;
#(
  parameter int unsigned SCORE_W    = 4,
  parameter int unsigned WIN_TARGET = 3,
  parameter int unsigned WIN_MARGIN = 1,
  parameter int unsigned MAX_ROUNDS = 9
) (
  input  logic             clk,
  input  logic             rst,
  rps_match_scorer_if.slave bus
);

  if ((WIN_TARGET > MAX_ROUNDS) || (WIN_MARGIN < 1) || (MAX_ROUNDS >= (2 ** SCORE_W)))
  begin : g_bad_cfg
    $error("rps_match_scorer: illegal WIN_TARGET/WIN_MARGIN/MAX_ROUNDS/SCORE_W combination");
  end

  localparam logic [SCORE_W-1:0]        TARGET = SCORE_W'(WIN_TARGET);
  localparam logic [SCORE_W-1:0]        LIMIT  = SCORE_W'(MAX_ROUNDS);
  localparam logic signed [SCORE_W:0]   MARGIN = (SCORE_W+1)'(WIN_MARGIN);

  state_e             state_q;
  logic [SCORE_W-1:0] score_a_q, score_b_q, draws_q, rounds_q;
  res_e               res_q;
  match_e             player_q;
  logic               vld_q, bad_q, over_q;

  res_e               judge_res;
  logic               judge_bad;
  logic [SCORE_W-1:0] next_a, next_b, next_d, next_r;
  logic signed [SCORE_W:0] lead_a, lead_b;
  match_e             decision;

  rps_match_scorer_judge u_judge (
    .move_a  (bus.move_a),
    .move_b  (bus.move_b),
    .res     (judge_res),
    .invalid (judge_bad)
  );

  // Decision is taken on the post-increment tallies so player/over move with the score.
  always_comb begin
    next_a   = score_a_q + SCORE_W'(judge_res == RES_A);
    next_b   = score_b_q + SCORE_W'(judge_res == RES_B);
    next_d   = draws_q + SCORE_W'(judge_res == RES_DRAW);
    next_r   = rounds_q + SCORE_W'(1);
    lead_a   = $signed({1'b0, next_a}) - $signed({1'b0, next_b});
    lead_b   = -lead_a;
    decision = PL_PLAY;
    if ((next_a >= TARGET) && (lead_a >= MARGIN)) begin
      decision = PL_A;
    end else if ((next_b >= TARGET) && (lead_b >= MARGIN)) begin
      decision = PL_B;
    end else if (next_r == LIMIT) begin
      if (lead_a == '0) begin
        decision = PL_TIE;
      end else if (lead_a[SCORE_W]) begin
        decision = PL_B;
      end else begin
        decision = PL_A;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StPlay;
      score_a_q <= '0;
      score_b_q <= '0;
      draws_q   <= '0;
      rounds_q  <= '0;
      res_q     <= RES_NONE;
      player_q  <= PL_PLAY;
      vld_q     <= 1'b0;
      bad_q     <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      bad_q <= 1'b0;
      if (bus.clr) begin
        state_q   <= StPlay;
        score_a_q <= '0;
        score_b_q <= '0;
        draws_q   <= '0;
        rounds_q  <= '0;
        res_q     <= RES_NONE;
        player_q  <= PL_PLAY;
        over_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StPlay: begin
            if (bus.start) begin
              if (judge_bad) begin
                bad_q <= 1'b1;
                res_q <= RES_NONE;
              end else begin
                score_a_q <= next_a;
                score_b_q <= next_b;
                draws_q   <= next_d;
                rounds_q  <= next_r;
                res_q     <= judge_res;
                vld_q     <= 1'b1;
                player_q  <= decision;
                over_q    <= (decision != PL_PLAY);
                if (decision != PL_PLAY) begin
                  state_q <= StDone;
                end
              end
            end
          end
          StDone: begin
            state_q <= StDone;
          end
        endcase
      end
    end
  end

  assign bus.score_a   = score_a_q;
  assign bus.score_b   = score_b_q;
  assign bus.draws     = draws_q;
  assign bus.rounds    = rounds_q;
  assign bus.round_vld = vld_q;
  assign bus.round_res = res_q;
  assign bus.bad_move  = bad_q;
  assign bus.player    = player_q;
  assign bus.over      = over_q;

endmodule

// File: tb/tb_rps_match_scorer.sv
// Scoreboard bench: three scorer configurations share one random stimulus stream and are
// checked every cycle against a rule-level reference model.
module tb_rps_match_scorer;

  typedef struct packed {
    logic [3:0] sa;
    logic [3:0] sb;
    logic [3:0] dr;
    logic [3:0] rd;
    logic       vld;
    logic [1:0] res;
    logic       bad;
    logic [1:0] pl;
    logic       ov;
  } obs_t;

  typedef obs_t [2:0] obs3_t;

  localparam int CFG_T   [3] = '{3, 3, 3};
  localparam int CFG_M   [3] = '{1, 2, 1};
  localparam int CFG_MAX [3] = '{9, 9, 4};

  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] S = 2'b10;
  localparam logic [1:0] P = 2'b11;
  localparam logic [1:0] N = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mv_a = 2'b00;
  logic [1:0] mv_b = 2'b00;

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    done = 1'b0;
  obs3_t exp_q[$];
  obs_t  m[3];

  always #5 clk = ~clk;

  rps_match_scorer_if #(.SCORE_W(4)) bus0 ();
  rps_match_scorer_if #(.SCORE_W(4)) bus1 ();
  rps_match_scorer_if #(.SCORE_W(4)) bus2 ();

  assign bus0.clr = clr;  assign bus0.start = start;
  assign bus0.move_a = mv_a;  assign bus0.move_b = mv_b;
  assign bus1.clr = clr;  assign bus1.start = start;
  assign bus1.move_a = mv_a;  assign bus1.move_b = mv_b;
  assign bus2.clr = clr;  assign bus2.start = start;
  assign bus2.move_a = mv_a;  assign bus2.move_b = mv_b;

  rps_match_scorer #(.SCORE_W(4), .WIN_TARGET(3), .WIN_MARGIN(1), .MAX_ROUNDS(9)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  rps_match_scorer #(.SCORE_W(4), .WIN_TARGET(3), .WIN_MARGIN(2), .MAX_ROUNDS(9)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );
  rps_match_scorer #(.SCORE_W(4), .WIN_TARGET(3), .WIN_MARGIN(1), .MAX_ROUNDS(4)) u_dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  // 0 invalid, 1 A wins, 2 B wins, 3 draw; each move beats the next one around the cycle
  // rock -> scissors -> paper -> rock.
  function automatic int outcome(input logic [1:0] a, input logic [1:0] b);
    int ia, ib;
    if (a == 2'b00 || b == 2'b00) return 0;
    ia = int'(a) - 1;
    ib = int'(b) - 1;
    if (ia == ib) return 3;
    if ((ia + 1) % 3 == ib) return 1;
    return 2;
  endfunction

  task automatic model_step(input bit c, input bit s, input logic [1:0] a, input logic [1:0] b);
    for (int k = 0; k < 3; k++) begin
      obs_t o;
      int   r, na, nb, nd, nr, pl;
      o     = m[k];
      o.vld = 1'b0;
      o.bad = 1'b0;
      if (c) begin
        o = '0;
      end else if (o.pl == 2'b00 && s) begin
        r = outcome(a, b);
        if (r == 0) begin
          o.bad = 1'b1;
          o.res = 2'b00;
        end else begin
          na = int'(o.sa) + ((r == 1) ? 1 : 0);
          nb = int'(o.sb) + ((r == 2) ? 1 : 0);
          nd = int'(o.dr) + ((r == 3) ? 1 : 0);
          nr = int'(o.rd) + 1;
          pl = 0;
          if (na >= CFG_T[k] && na - nb >= CFG_M[k]) pl = 2;
          else if (nb >= CFG_T[k] && nb - na >= CFG_M[k]) pl = 1;
          else if (nr == CFG_MAX[k]) pl = (na > nb) ? 2 : (nb > na) ? 1 : 3;
          o.sa  = 4'(na);
          o.sb  = 4'(nb);
          o.dr  = 4'(nd);
          o.rd  = 4'(nr);
          o.vld = 1'b1;
          o.res = (r == 1) ? 2'b10 : (r == 2) ? 2'b01 : 2'b11;
          o.pl  = 2'(pl);
          o.ov  = (pl != 0);
        end
      end
      m[k] = o;
    end
  endtask

  // Called one time unit after a rising edge; the expectation is queued once its edge passes.
  task automatic cycle(input bit c, input bit s, input logic [1:0] a, input logic [1:0] b);
    obs3_t e;
    clr   = c;
    start = s;
    mv_a  = a;
    mv_b  = b;
    model_step(c, s, a, b);
    e = {m[2], m[1], m[0]};
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    clr   = 1'b0;
    start = 1'b0;
  endtask

  task automatic reset_pulse();
    clr   = 1'b0;
    start = 1'b0;
    #5;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) m[k] = '0;
    @(posedge clk);
    #1;
    exp_q.push_back({m[2], m[1], m[0]});
    rst = 1'b1;
  endtask

  function automatic obs3_t sample();
    obs3_t s;
    s[0] = {bus0.score_a, bus0.score_b, bus0.draws, bus0.rounds, bus0.round_vld,
            bus0.round_res, bus0.bad_move, bus0.player, bus0.over};
    s[1] = {bus1.score_a, bus1.score_b, bus1.draws, bus1.rounds, bus1.round_vld,
            bus1.round_res, bus1.bad_move, bus1.player, bus1.over};
    s[2] = {bus2.score_a, bus2.score_b, bus2.draws, bus2.rounds, bus2.round_vld,
            bus2.round_res, bus2.bad_move, bus2.player, bus2.over};
    return s;
  endfunction

  task automatic check(input string tag, input obs3_t got, input obs3_t want);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (got[k] !== want[k]) begin
        n_bad++;
        $display({"FAIL %s dut%0d t=%0t: got sa=%0d sb=%0d d=%0d r=%0d vld=%b res=%b bad=%b ",
                  "pl=%b ov=%b, want sa=%0d sb=%0d d=%0d r=%0d vld=%b res=%b bad=%b pl=%b ov=%b"},
                 tag, k, $time, got[k].sa, got[k].sb, got[k].dr, got[k].rd, got[k].vld,
                 got[k].res, got[k].bad, got[k].pl, got[k].ov, want[k].sa, want[k].sb,
                 want[k].dr, want[k].rd, want[k].vld, want[k].res, want[k].bad, want[k].pl,
                 want[k].ov);
      end
    end
  endtask

  // Monitor: async reset is checked as it happens, otherwise one expectation per clock.
  initial begin
    obs3_t e;
    forever begin
      @(negedge clk or negedge rst);
      if (!rst) begin
        #1;
        check("async_reset", sample(), '0);
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("round", sample(), e);
      end else if (done) begin
        break;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  // Stimulus: directed match scenarios first, then a long random stream.
  initial begin
    for (int k = 0; k < 3; k++) m[k] = '0;
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    cycle(1, 0, N, N);
    repeat (4) cycle(0, 1, R, S);
    cycle(1, 0, N, N);
    cycle(0, 1, P, P);
    cycle(0, 1, N, R);
    cycle(0, 1, S, N);
    cycle(1, 0, N, N);
    for (int i = 0; i < 6; i++) begin
      if (i == 1 || i == 3) cycle(0, 1, S, R);
      else cycle(0, 1, R, S);
    end
    cycle(1, 0, N, N);
    cycle(0, 1, R, S);
    cycle(0, 1, S, R);
    cycle(0, 1, P, P);
    cycle(0, 1, R, R);
    cycle(0, 1, R, R);
    cycle(1, 0, N, N);
    cycle(0, 1, P, R);
    cycle(0, 1, R, P);
    cycle(0, 1, S, P);
    cycle(1, 1, R, S);
    cycle(0, 1, R, S);
    cycle(0, 0, R, S);
    cycle(1, 0, N, N);
    cycle(0, 1, R, S);
    cycle(0, 1, S, R);
    cycle(0, 1, R, S);
    cycle(0, 1, S, R);
    reset_pulse();
    cycle(0, 1, P, R);

    for (int i = 0; i < 3000; i++) begin
      logic [1:0] a, b;
      a = ($urandom % 8 == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      b = ($urandom % 8 == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      if ($urandom % 250 == 0) reset_pulse();
      else cycle(($urandom % 14) == 0, ($urandom % 4) != 0, a, b);
    end
    cycle(0, 0, N, N);
    done = 1'b1;
  end

endmodule
